// File: rtl/operand_collector.sv
// rtl/operand_collector.sv - serial A/B/C operand collector around a combinational multiplicator
// Results are handed off over valid/ready; in_ready, op_idx and out_valid decode from state only.
module operand_collector #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   c,
  input  logic [3*WIDTH-1:0] mult_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3*WIDTH-1:0] out_product,
  output logic [1:0]         op_idx,
  output logic [CNT_W-1:0]   res_count
);

  typedef enum logic [2:0] {S_A, S_B, S_C, S_CAP, S_HOLD} state_t;

  state_t state, state_next;
  logic   in_fire;
  logic   out_fire;

  always_ff @(posedge clk) begin
    if (rst) state <= S_A;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    op_idx     = 2'd3;
    unique case (state)
      S_A: begin
        in_ready = 1'b1;
        op_idx   = 2'd0;
        if (in_valid) state_next = S_B;
      end
      S_B: begin
        in_ready = 1'b1;
        op_idx   = 2'd1;
        if (in_valid) state_next = S_C;
      end
      S_C: begin
        in_ready = 1'b1;
        op_idx   = 2'd2;
        if (in_valid) state_next = S_CAP;
      end
      // One settle cycle so mult_in reflects the freshly registered c.
      S_CAP: state_next = S_HOLD;
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_A;
      end
      default: state_next = S_A;
    endcase
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      a           <= '0;
      b           <= '0;
      c           <= '0;
      out_product <= '0;
      res_count   <= '0;
    end else begin
      if (in_fire && state == S_A) a <= in_data;
      if (in_fire && state == S_B) b <= in_data;
      if (in_fire && state == S_C) c <= in_data;
      if (state == S_CAP) out_product <= mult_in;
      if (out_fire) res_count <= res_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_collector.sv
// tb/tb_operand_collector.sv - scoreboard bench for operand_collector
module tb_operand_collector;

  localparam int WIDTH = 5;
  localparam int CNT_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [WIDTH-1:0]   a, b, c;
  logic [3*WIDTH-1:0] mult_in;
  logic               out_valid;
  logic               out_ready;
  logic [3*WIDTH-1:0] out_product;
  logic [1:0]         op_idx;
  logic [CNT_W-1:0]   res_count;

  int total = 0;
  int bad = 0;
  int got = 0;
  int n_res = 0;
  logic [3*WIDTH-1:0] exp_q[$];

  operand_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .a(a), .b(b), .c(c), .mult_in(mult_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .op_idx(op_idx), .res_count(res_count)
  );

  // Combinational multiplicator model
  assign mult_in = (3*WIDTH)'(a) * (3*WIDTH)'(b) * (3*WIDTH)'(c);

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(out_product), 32'hFFFF_FFFF);
      end else begin
        chk("out_product", 32'(out_product), 32'(exp_q.pop_front()));
      end
      got++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic seq(input logic [WIDTH-1:0] va, vb, vc, input int gap,
                     input logic [3*WIDTH-1:0] prod);
    exp_q.push_back(prod);
    n_res++;
    send(va);
    for (int i = 0; i < gap; i++) begin
      chk("gap_op_idx_b", 32'(op_idx), 32'd1);
      chk("gap_in_ready_b", 32'(in_ready), 32'd1);
      tick();
    end
    send(vb);
    for (int i = 0; i < gap; i++) begin
      chk("gap_op_idx_c", 32'(op_idx), 32'd2);
      chk("gap_b_held", 32'(b), 32'(vb));
      tick();
    end
    send(vc);
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (got < n_res && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("result_timeout", 32'(got >= n_res), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    do_reset();
    chk("rst_op_idx", 32'(op_idx), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_abc", {17'd0, a, b, c}, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_product", 32'(out_product), 32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);

    // 3*4*5 back to back
    seq(5'd3, 5'd4, 5'd5, 0, 15'd60);
    chk("t1_abc", {17'd0, a, b, c}, {17'd0, 5'd3, 5'd4, 5'd5});
    chk("t1_cap_valid", 32'(out_valid), 32'd0);
    chk("t1_cap_op_idx", 32'(op_idx), 32'd3);
    chk("t1_cap_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_product", 32'(out_product), 32'd60);
    chk("t1_hold_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_res_count", 32'(res_count), 32'd1);
    chk("t1_op_idx", 32'(op_idx), 32'd0);

    // Maximum operands with 2-cycle gaps
    seq(5'd31, 5'd31, 5'd31, 2, 15'd29791);
    wait_result();
    chk("t2_res_count", 32'(res_count), 32'd2);

    // Stalled consumer, in_valid pulses ignored
    out_ready = 1'b0;
    seq(5'd2, 5'd0, 5'd7, 0, 15'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0];
      in_data  = 5'd9;
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_product", 32'(out_product), 32'd0);
      chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
      chk("t3_hold_res_count", 32'(res_count), 32'd2);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t3_res_count", 32'(res_count), 32'd3);
    chk("t3_valid_drop", 32'(out_valid), 32'd0);
    chk("t3_a_kept", 32'(a), 32'd2);
    chk("t3_c_kept", 32'(c), 32'd7);

    // Mid-sequence reset
    send(5'd9);
    send(5'd6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_op_idx", 32'(op_idx), 32'd0);
    chk("t4_abc", {17'd0, a, b, c}, 32'd0);
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    chk("t4_res_count", 32'(res_count), 32'd0);
    seq(5'd1, 5'd2, 5'd3, 0, 15'd6);
    wait_result();
    chk("t4_res_count_after", 32'(res_count), 32'd1);

    // Counter wrap over 17 results
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      seq(5'(i), 5'd1, 5'd2, 0, 15'(2 * i));
      wait_result();
      chk("t5_res_count", 32'(res_count), 32'(i % 16));
    end

    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
